// File: rtl/fcpu_uart_tx.sv
// fcpu_uart_tx: 8N1 UART transmitter for the core byte output stream.
// A small circular FIFO decouples the core handshake from the baud rate.
module fcpu_uart_tx #(
   parameter int unsigned CLK_DIV    = 868,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        nrst,
   input  logic [7:0]                  io_o_data,
   input  logic                        io_o_valid,
   output logic                        io_o_ready,
   output logic                        txd,
   output logic                        tx_busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned FCW   = PTR_W + 1;
   localparam int unsigned CNT_W = $clog2(CLK_DIV);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [7:0]       shift, shift_n;
   logic             txd_n;
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [FCW-1:0]   count_n;
   logic             push, pop, fifo_empty, bit_end;

   // Ready never looks at valid; a full FIFO stays closed even on a pop edge.
   assign fifo_empty = (fifo_count == '0);
   assign io_o_ready = nrst && (fifo_count != FCW'(FIFO_DEPTH));
   assign push       = io_o_valid && io_o_ready;
   assign bit_end    = (baud_cnt == CNT_W'(CLK_DIV - 1));

   // Occupancy update; push and pop on the same edge cancel out.
   always_comb begin
      count_n = fifo_count;
      case ({push, pop})
         2'b10:   count_n = fifo_count + FCW'(1);
         2'b01:   count_n = fifo_count - FCW'(1);
         default: count_n = fifo_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_count <= count_n;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= io_o_data;
   end

   // Frame sequencer; txd_n is the line level for the cycle after this edge.
   always_comb begin
      state_n    = state;
      baud_cnt_n = baud_cnt + CNT_W'(1);
      bit_idx_n  = bit_idx;
      shift_n    = shift;
      txd_n      = txd;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            baud_cnt_n = '0;
            txd_n      = 1'b1;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_n = mem[rd_ptr];
               state_n = START;
               txd_n   = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               baud_cnt_n = '0;
               bit_idx_n  = '0;
               state_n    = DATA;
               txd_n      = shift[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_cnt_n = '0;
               shift_n    = {1'b0, shift[7:1]};
               if (bit_idx == 3'd7) begin
                  state_n = STOP;
                  txd_n   = 1'b1;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
                  txd_n     = shift[1];
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_cnt_n = '0;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_n = mem[rd_ptr];
                  state_n = START;
                  txd_n   = 1'b0;
               end else begin
                  state_n = IDLE;
                  txd_n   = 1'b1;
               end
            end
         end
         default: begin
            state_n    = IDLE;
            baud_cnt_n = '0;
            txd_n      = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         txd      <= 1'b1;
         tx_busy  <= 1'b0;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_cnt_n;
         bit_idx  <= bit_idx_n;
         shift    <= shift_n;
         txd      <= txd_n;
         tx_busy  <= (state_n != IDLE) || (count_n != '0);
      end
   end

endmodule

// File: tb/tb_fcpu_uart_tx.sv
// Bench for fcpu_uart_tx: frame-time reference model checked every cycle,
// a line decoder, a vector table of single frames and hand-written corner cases.
module tb_fcpu_uart_tx;

   localparam int unsigned CLK_DIV = 4;
   localparam int unsigned DEPTH   = 4;
   localparam int          FRAME   = 10 * CLK_DIV;

   logic       clk = 1'b0;
   logic       nrst, io_o_valid, io_o_ready, txd, tx_busy;
   logic [7:0] io_o_data;
   logic [2:0] fifo_count;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   fcpu_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .io_o_data  (io_o_data),
      .io_o_valid (io_o_valid),
      .io_o_ready (io_o_ready),
      .txd        (txd),
      .tx_busy    (tx_busy),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: queue of waiting bytes plus position within the current frame.
   logic [7:0] mq[$];
   logic [7:0] acc_q[$];
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   bit         m_active = 1'b0;
   int         m_t = 0;
   logic [7:0] m_cur = 8'h00;

   function automatic logic frame_bit(input logic [7:0] b, input int slot);
      if (slot == 0) return 1'b0;
      if (slot >= 9) return 1'b1;
      return b[3'(slot - 1)];
   endfunction

   always @(posedge clk) begin
      bit m_push, m_pop;
      cyc++;
      if (!nrst) begin
         mq.delete();
         m_active = 1'b0;
         m_t      = 0;
      end else begin
         m_push = io_o_valid && (mq.size() < DEPTH);
         m_pop  = (mq.size() != 0) && (!m_active || m_t == FRAME - 1);
         if (m_active) begin
            if (m_t == FRAME - 1) m_active = 1'b0;
            else m_t++;
         end
         if (m_pop) begin
            m_cur    = mq.pop_front();
            m_active = 1'b1;
            m_t      = 0;
         end
         if (m_push) begin
            mq.push_back(io_o_data);
            acc_q.push_back(io_o_data);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_txd", 32'(txd), 32'(m_active ? frame_bit(m_cur, m_t / CLK_DIV) : 1'b1));
         check("cyc_fifo_count", 32'(fifo_count), 32'(mq.size()));
         check("cyc_tx_busy", 32'(tx_busy), 32'(m_active || mq.size() != 0));
         check("cyc_io_o_ready", 32'(io_o_ready), 32'(nrst && mq.size() != DEPTH));
      end
   end

   // Line decoder: start bit detection, mid-bit sampling, aborted by reset.
   bit         mon_busy = 1'b0;
   int         mon_t = 0;
   logic [7:0] mon_b = 8'h00;

   always @(negedge clk) begin
      if (nrst !== 1'b1) begin
         mon_busy = 1'b0;
      end else if (!mon_busy) begin
         if (txd === 1'b0) begin
            mon_busy = 1'b1;
            mon_t    = 0;
         end
      end else begin
         mon_t++;
         if (mon_t >= 6 && mon_t <= 34 && (mon_t % 4) == 2) mon_b[3'((mon_t - 6) / 4)] = txd;
         if (mon_t == FRAME - 1) begin
            mon_busy = 1'b0;
            rx_q.push_back(mon_b);
         end
      end
   end

   task automatic to_neg_after(input int e);
      do @(negedge clk); while (cyc < e);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while ((tx_busy || fifo_count != 3'd0) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) check("idle_timeout", 32'(tx_busy), 32'(1'b0));
      @(negedge clk);
   endtask

   task automatic clear_logs();
      acc_q.delete();
      rx_q.delete();
      exp_q.delete();
   endtask

   task automatic check_rx(input string name);
      check({name, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (i < rx_q.size()) check($sformatf("%s_byte%0d", name, i), 32'(rx_q[i]), 32'(exp_q[i]));
      rx_q.delete();
      exp_q.delete();
   endtask

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;   // bit 0 = start, bits 1..8 = data LSB first, bit 9 = stop
   } vec_t;

   vec_t vecs[6];
   int   acc_cyc[7];

   initial begin
      int n0, b, guard, seen_full, hi;
      logic rdy;

      vecs[0] = '{8'h55, 10'h2AA};
      vecs[1] = '{8'h00, 10'h200};
      vecs[2] = '{8'hFF, 10'h3FE};
      vecs[3] = '{8'h80, 10'h300};
      vecs[4] = '{8'h01, 10'h202};
      vecs[5] = '{8'h3C, 10'h278};

      nrst = 1'b0; io_o_valid = 1'b0; io_o_data = 8'h00;
      @(posedge clk); #1 chk_en = 1'b1;
      @(negedge clk);
      check("rst_txd", 32'(txd), 32'(1'b1));
      check("rst_count", 32'(fifo_count), 32'(3'd0));
      check("rst_busy", 32'(tx_busy), 32'(1'b0));
      check("rst_ready", 32'(io_o_ready), 32'(1'b0));
      @(posedge clk); #1 nrst = 1'b1;
      @(negedge clk);
      check("rel_ready", 32'(io_o_ready), 32'(1'b1));

      // Single frames from the vector table, slot by slot
      foreach (vecs[v]) begin
         wait_idle(); clear_logs();
         io_o_valid = 1'b1; io_o_data = vecs[v].data;
         @(posedge clk); #1 io_o_valid = 1'b0;
         @(negedge clk);
         check("tbl_pre_start", 32'(txd), 32'(1'b1));
         check("tbl_count1", 32'(fifo_count), 32'(3'd1));
         for (int s = 0; s < 10; s++)
            for (int k = 0; k < CLK_DIV; k++) begin
               @(negedge clk);
               check($sformatf("tbl%0d_slot%0d", v, s), 32'(txd), 32'(vecs[v].frame[s]));
            end
         @(negedge clk);
         check("tbl_idle_busy", 32'(tx_busy), 32'(1'b0));
         check("tbl_idle_txd", 32'(txd), 32'(1'b1));
         exp_q.push_back(vecs[v].data);
         check_rx("tbl_rx");
      end

      // Back-to-back frames
      wait_idle(); clear_logs();
      io_o_valid = 1'b1; io_o_data = 8'hA5;
      @(posedge clk); #1 n0 = cyc; io_o_data = 8'h3C;
      @(posedge clk); #1 io_o_valid = 1'b0;
      to_neg_after(n0 + 1);         check("bb_start1", 32'(txd), 32'(1'b0));
      to_neg_after(n0 + FRAME);     check("bb_stop1", 32'(txd), 32'(1'b1));
      to_neg_after(n0 + FRAME + 1); check("bb_start2", 32'(txd), 32'(1'b0));
      wait_idle();
      exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
      check_rx("bb_rx");

      // FIFO full with valid held
      wait_idle(); clear_logs();
      seen_full = 0; guard = 0; b = 1;
      io_o_valid = 1'b1; io_o_data = 8'h01;
      while (b <= 6 && guard < 500) begin
         rdy = io_o_ready;
         @(posedge clk); #1;
         if (rdy) begin
            acc_cyc[b] = cyc;
            b++;
            if (b > 6) io_o_valid = 1'b0;
            else io_o_data = 8'(b);
         end
         @(negedge clk);
         guard++;
         if (fifo_count == 3'd4) begin
            seen_full++;
            check("full_ready_low", 32'(io_o_ready), 32'(1'b0));
         end
      end
      io_o_valid = 1'b0;
      check("full_all_accepted", 32'(b), 32'(7));
      check("full_reached", 32'(seen_full > 0), 32'(1'b1));
      check("full_06_accept_gap", 32'(acc_cyc[6] - acc_cyc[1]), 32'(FRAME + 2));
      wait_idle();
      for (int i = 1; i <= 6; i++) exp_q.push_back(8'(i));
      check_rx("full_rx");

      // Push and pop on the same STOP-end edge
      wait_idle(); clear_logs();
      io_o_valid = 1'b1; io_o_data = 8'h21;
      @(posedge clk); #1 n0 = cyc; io_o_data = 8'h22;
      @(posedge clk); #1 io_o_data = 8'h23;
      @(posedge clk); #1 io_o_valid = 1'b0;
      to_neg_after(n0 + FRAME);
      check("pp_pre_count", 32'(fifo_count), 32'(3'd2));
      io_o_valid = 1'b1; io_o_data = 8'h24;
      @(posedge clk); #1 io_o_valid = 1'b0;
      @(negedge clk);
      check("pp_count", 32'(fifo_count), 32'(3'd2));
      check("pp_start", 32'(txd), 32'(1'b0));
      wait_idle();
      for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'h21 + i));
      check_rx("pp_rx");

      // Reset during data bit 3 with two bytes queued
      wait_idle(); clear_logs();
      io_o_valid = 1'b1; io_o_data = 8'hFF;
      @(posedge clk); #1 n0 = cyc; io_o_data = 8'h11;
      @(posedge clk); #1 io_o_data = 8'h22;
      @(posedge clk); #1 io_o_valid = 1'b0;
      to_neg_after(n0 + 16);
      @(posedge clk); #1 nrst = 1'b0;
      #1;
      check("mid_rst_ready_low", 32'(io_o_ready), 32'(1'b0));
      check("mid_rst_count_pre", 32'(fifo_count), 32'(3'd2));
      @(posedge clk); #1;
      check("mid_rst_txd", 32'(txd), 32'(1'b1));
      check("mid_rst_count", 32'(fifo_count), 32'(3'd0));
      check("mid_rst_busy", 32'(tx_busy), 32'(1'b0));
      nrst = 1'b1;
      #1 check("mid_rst_ready_high", 32'(io_o_ready), 32'(1'b1));
      hi = 0;
      repeat (3 * FRAME) begin
         @(negedge clk);
         if (txd === 1'b1) hi++;
      end
      check("mid_rst_line_quiet", 32'(hi), 32'(3 * FRAME));
      check_rx("mid_rst_rx");

      // Nine single bytes to wrap both pointers
      wait_idle(); clear_logs();
      for (int i = 0; i < 9; i++) begin
         io_o_valid = 1'b1; io_o_data = 8'(8'h10 + i);
         @(posedge clk); #1 io_o_valid = 1'b0;
         exp_q.push_back(8'(8'h10 + i));
         wait_idle();
      end
      check_rx("wrap_rx");

      // Random traffic: dense then sparse
      wait_idle(); clear_logs();
      for (int i = 0; i < 1200; i++) begin
         @(negedge clk);
         io_o_valid = ($urandom_range(0, (i < 600) ? 3 : 39) == 0);
         io_o_data  = 8'($urandom);
      end
      @(negedge clk); io_o_valid = 1'b0;
      wait_idle();
      exp_q = acc_q;
      check_rx("rand_rx");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
